// File: rtl/mvau_stream_ctrl_pkg.sv
// Shared state type and fold/width helpers for the MVAU input stream controller.
package mvau_stream_ctrl_pkg;

  localparam int MIN_CNT_BW = 1;

  typedef enum logic {
    ST_WRITE = 1'b0,
    ST_READ  = 1'b1
  } state_t;

  function automatic int calc_sf(input int matrix_w, input int simd);
    return matrix_w / simd;
  endfunction

  function automatic int calc_nf(input int matrix_h, input int pe);
    return matrix_h / pe;
  endfunction

  // A counter over n values still needs one bit when n==1.
  function automatic int cnt_bw(input int n);
    return (n > 1) ? $clog2(n) : MIN_CNT_BW;
  endfunction

endpackage

// File: rtl/mvau_inp_buffer.sv
// One-vector activation store: synchronous write, asynchronous read, no reset.
// Read data reflects rd_addr in the same cycle; no backpressure.
module mvau_inp_buffer #(
  parameter int DEPTH = 4,
  parameter int DW    = 8,
  parameter int AW    = 2
) (
  input  logic          aclk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_dat,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_dat
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge aclk) begin
    if (wr_en) mem[wr_addr] <= wr_dat;
  end

  assign rd_dat = mem[rd_addr];

endmodule

// File: rtl/mvau_stream_ctrl.sv
// Buffers one SF-word input vector and replays it NF times, issuing weight addresses; outputs 1 cycle after issue.
// A held output beat stalls issue and input; wmem_addr re-reads the held beat so weights stay aligned.
module mvau_stream_ctrl
  import mvau_stream_ctrl_pkg::*;
#(
  parameter int SIMD         = 2,
  parameter int TI           = 4,
  parameter int MatrixW      = 8,
  parameter int MatrixH      = 4,
  parameter int PE           = 2,
  parameter int WMEM_DEPTH   = 8,
  parameter int WMEM_ADDR_BW = 3
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    in_v,
  input  logic [SIMD*TI-1:0]      in_data,
  output logic                    in_rdy,
  output logic [WMEM_ADDR_BW-1:0] wmem_addr,
  output logic [SIMD*TI-1:0]      out_inp,
  output logic                    out_v,
  output logic                    out_sf_first,
  output logic                    out_sf_last,
  input  logic                    out_rdy
);

  localparam int SF    = calc_sf(MatrixW, SIMD);
  localparam int NF    = calc_nf(MatrixH, PE);
  localparam int SF_BW = cnt_bw(SF);
  localparam int NF_BW = cnt_bw(NF);
  localparam int DW    = SIMD * TI;

  localparam logic [SF_BW-1:0]        SF_MAX   = SF_BW'(SF - 1);
  localparam logic [NF_BW-1:0]        NF_MAX   = NF_BW'(NF - 1);
  localparam logic [WMEM_ADDR_BW-1:0] ADDR_MAX = WMEM_ADDR_BW'(WMEM_DEPTH - 1);

  state_t                  state;
  logic [SF_BW-1:0]        sf_cnt;
  logic [NF_BW-1:0]        nf_cnt;
  logic [WMEM_ADDR_BW-1:0] addr_cnt;
  logic [WMEM_ADDR_BW-1:0] last_addr;
  logic [DW-1:0]           ibuf_dat;
  logic                    wr_phase;
  logic                    slot_free;
  logic                    adv;

  assign wr_phase  = (state == ST_WRITE);
  assign slot_free = !out_v || out_rdy;
  assign adv       = !areset && slot_free && (!wr_phase || in_v);
  assign in_rdy    = wr_phase && slot_free && !areset;
  // On a stall the memory re-reads the held beat so its registered output does not move.
  assign wmem_addr = areset ? '0 : (adv ? addr_cnt : last_addr);

  mvau_inp_buffer #(
    .DEPTH (SF),
    .DW    (DW),
    .AW    (SF_BW)
  ) u_ibuf (
    .aclk    (aclk),
    .wr_en   (adv && wr_phase),
    .wr_addr (sf_cnt),
    .wr_dat  (in_data),
    .rd_addr (sf_cnt),
    .rd_dat  (ibuf_dat)
  );

  always_ff @(posedge aclk) begin
    if (areset) begin
      state        <= ST_WRITE;
      sf_cnt       <= '0;
      nf_cnt       <= '0;
      addr_cnt     <= '0;
      last_addr    <= '0;
      out_v        <= 1'b0;
      out_sf_first <= 1'b0;
      out_sf_last  <= 1'b0;
      out_inp      <= '0;
    end else if (adv) begin
      out_v        <= 1'b1;
      out_inp      <= wr_phase ? in_data : ibuf_dat;
      out_sf_first <= (sf_cnt == '0);
      out_sf_last  <= (sf_cnt == SF_MAX);
      last_addr    <= addr_cnt;
      addr_cnt     <= (addr_cnt == ADDR_MAX) ? '0 : addr_cnt + 1'b1;
      if (sf_cnt == SF_MAX) begin
        sf_cnt <= '0;
        // With NF==1 the neuron fold wraps immediately and the block stays in WRITE.
        if (nf_cnt == NF_MAX) begin
          nf_cnt <= '0;
          state  <= ST_WRITE;
        end else begin
          nf_cnt <= nf_cnt + 1'b1;
          state  <= ST_READ;
        end
      end else begin
        sf_cnt <= sf_cnt + 1'b1;
      end
    end else if (out_rdy) begin
      out_v <= 1'b0;
    end
  end

endmodule

// File: doc/mvau_stream_ctrl.md
# mvau_stream_ctrl

Control stage directly upstream of the MVAU weight memory and PE array. It accepts the input activation stream, buffers one input vector (SF words), and replays it NF times. For each beat it drives the weight-memory read address and produces the matching SIMD input word, valid flag and accumulator framing. Its outputs line up cycle-for-cycle with the weight memory's registered output.

## Interface
Parameters:
- SIMD, 2: input elements per beat
- TI, 4: input element width (bits)
- MatrixW, 8: matrix columns; SF = MatrixW/SIMD
- MatrixH, 4: matrix rows; NF = MatrixH/PE
- PE, 2: processing elements (used only for NF)
- WMEM_DEPTH, 8: must equal SF*NF
- WMEM_ADDR_BW, 3: address width; ≥ clog2(WMEM_DEPTH), minimum 1

Ports:
- aclk  in  1  clock
- areset  in  1  reset; synchronous, active-high
- in_v  in  1  input stream valid
- in_data  in  SIMD*TI  input stream word
- in_rdy  out  1  input stream ready
- wmem_addr  out  WMEM_ADDR_BW  weight memory read address (single-cycle registered-read memory)
- out_inp  out  SIMD*TI  input word aligned with the weight memory output
- out_v  out  1  output beat valid; weights for this beat are on the weight memory output this same cycle
- out_sf_first  out  1  first SIMD fold of a neuron; PE clears its accumulator
- out_sf_last  out  1  last SIMD fold; accumulator result complete
- out_rdy  in  1  downstream ready

## Operation
- Counters: sf_cnt (0..SF-1), nf_cnt (0..NF-1), addr_cnt (0..WMEM_DEPTH-1). addr_cnt is the address of the next beat to issue. last_addr is the address of the beat held in the output stage.
- States:
  - WRITE (nf_cnt==0): consumes the stream.
  - READ (nf_cnt>0): replays from the input buffer.
- adv = (!out_v || out_rdy) && (state==READ || in_v).
- in_rdy = (state==WRITE) && (!out_v || out_rdy) && !areset.
- On adv:
  - In WRITE, in_data is written to ibuf[sf_cnt].
  - out_inp <= (WRITE ? in_data : ibuf[sf_cnt]).
  - out_sf_first <= (sf_cnt==0); out_sf_last <= (sf_cnt==SF-1).
  - last_addr <= addr_cnt.
  - sf_cnt increments. On wrap, nf_cnt increments. On nf wrap, state returns to WRITE.
  - addr_cnt increments and wraps WMEM_DEPTH-1 -> 0.
- out_v update: out_v <= 1 on adv; out_v <= 0 when out_v && out_rdy && !adv.
- wmem_addr = adv ? addr_cnt : last_addr. During a stall the memory therefore re-reads the held beat's address and its output stays stable. This is a combinational path from out_rdy/in_v to wmem_addr.
- Transitions:
  - WRITE -> READ after beat sf==SF-1 when NF>1.
  - READ -> WRITE after beat sf==SF-1, nf==NF-1.
  - NF==1: the block never leaves WRITE.
- SF==1: out_sf_first and out_sf_last are both 1 on every beat.
- ibuf contents are not reset.

## Timing
- Reset values:
  - out_v=0, out_sf_first=0, out_sf_last=0, out_inp=0.
  - Counters and last_addr = 0; state=WRITE.
  - wmem_addr=0; in_rdy=0 while areset is high.
- Latency: an input accepted at cycle t (in_v && in_rdy) appears on out_inp/out_v at t+1. wmem_addr is issued at t, and the weight memory output is valid at t+1.
- Throughput: one beat/cycle with out_rdy held high. A replay vector follows its WRITE pass with no bubble.
- Stall: while out_v && !out_rdy, all outputs hold, wmem_addr=last_addr and in_rdy=0.
- Simultaneous drain and issue (out_rdy && adv): out_v stays 1 and the new beat replaces the old.
- areset mid-vector: the partial vector is discarded; the first beat after reset is again address 0, sf=0, WRITE.

## Structure
- Package mvau_stream_ctrl_pkg holds:
  - state typedef (WRITE, READ)
  - SF/NF derivation functions
  - clog2-based counter width constants
- Sub-module mvau_inp_buffer: SF x (SIMD*TI) distributed RAM, synchronous write, asynchronous read.
- Counters and the FSM stay in the top module.

## Test plan
Defaults (SF=4, NF=2) unless noted.
- Continuous input 0x11,0x22,0x33,0x44 with out_rdy=1 -> out_inp 11,22,33,44,11,22,33,44 on 8 consecutive cycles; wmem_addr 0..7; out_sf_first on beats 0 and 4, out_sf_last on beats 3 and 7; in_rdy=0 during beats 4-7.
- out_rdy low for 3 cycles while beat addr 5 is on the output -> out_inp, out_v and flags are frozen and wmem_addr=5 throughout; resumes with addr 6 the cycle after out_rdy rises.
- in_v toggling 1,0,1,0 in WRITE -> out_v has bubbles matching in_v; no bubbles during READ.
- Two back-to-back vectors -> after addr 7, wmem_addr wraps to 0 and the second vector's first word is accepted with no idle cycle.
- areset asserted after beat addr 2, then released -> all outputs are 0 during reset; the first output after reset is addr 0, out_sf_first=1, data taken from the stream.
- Config SF=1, NF=1 (MatrixW=2, MatrixH=2) -> wmem_addr is constantly 0, out_sf_first=out_sf_last=1 on every beat, and the block never enters READ.
